rob: RTL and testbench

Reorder buffer for the Tomasulo core. Sits directly downstream of dispatch, alongside the `rat`. It hands out the ROB tag that dispatch writes into the `rat` as `rob_tag_in`, and captures results broadcast on the CDB. It retires instructions in program order to the architectural register file and raises the pipeline-wide `flush` when a mispredicted instruction commits.

---
 rtl/rob_if.sv | 39 +++
 rtl/rob.sv | 95 +++++++++
 tb/tb_rob.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Dispatch/CDB/commit bundle for the reorder buffer.
// master is the pipeline side; slave is the rob itself.
interface rob_if #(
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             cdb_mispredict;

  logic [TAG_W-1:0] src_tag;
  logic             src_ready;
  logic [XLEN-1:0]  src_value;

  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_value;
  logic [TAG_W-1:0] commit_tag;

  logic             flush;

  modport master (
    output alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_value, cdb_mispredict, src_tag,
    input  alloc_ready, alloc_tag, src_ready, src_value,
           commit_valid, commit_rd, commit_value, commit_tag, flush
  );

  modport slave (
    input  alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_value, cdb_mispredict, src_tag,
    output alloc_ready, alloc_tag, src_ready, src_value,
           commit_valid, commit_rd, commit_value, commit_tag, flush
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: hands out tags at dispatch, captures CDB results and
// retires in program order; a committing mispredict squashes everything.
module rob #(
  parameter int DEPTH = 32,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  rob_if.slave  bus
);
  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] mispredict;
  logic [4:0]       rd_q    [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             flush_q;

  logic alloc_ready;
  logic alloc_fire;
  logic cdb_fire;
  logic commit_fire;
  logic flush_fire;
  logic src_bypass;

  // Full/empty is decided from count alone, since head==tail is ambiguous.
  assign alloc_ready = (count != CNT_W'(DEPTH)) && !flush_q;
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign cdb_fire    = bus.cdb_valid && busy[bus.cdb_tag] && !flush_q;
  assign commit_fire = busy[head] && ready[head] && !flush_q;
  assign flush_fire  = commit_fire && mispredict[head];
  assign src_bypass  = bus.cdb_valid && (bus.cdb_tag == bus.src_tag) && busy[bus.src_tag];

  assign bus.alloc_ready  = alloc_ready;
  assign bus.alloc_tag    = tail;
  assign bus.commit_valid = commit_fire;
  assign bus.commit_rd    = rd_q[head];
  assign bus.commit_value = value_q[head];
  assign bus.commit_tag   = head;
  assign bus.flush        = flush_q;
  assign bus.src_ready    = ready[bus.src_tag] || src_bypass;
  assign bus.src_value    = src_bypass ? bus.cdb_value : value_q[bus.src_tag];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      ready      <= '0;
      mispredict <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      flush_q    <= 1'b0;
    end else begin
      flush_q <= flush_fire;
      // The mispredicted instruction still retires, but nothing else survives this edge.
      if (flush_fire) begin
        busy  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (alloc_fire) begin
          busy[tail]       <= 1'b1;
          ready[tail]      <= 1'b0;
          mispredict[tail] <= 1'b0;
          tail             <= tail + TAG_W'(1);
        end
        if (cdb_fire) begin
          ready[bus.cdb_tag]      <= 1'b1;
          mispredict[bus.cdb_tag] <= bus.cdb_mispredict;
        end
        if (commit_fire) begin
          busy[head] <= 1'b0;
          head       <= head + TAG_W'(1);
        end
        count <= count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire && !flush_fire) begin
      rd_q[tail] <= bus.alloc_rd;
    end
    if (cdb_fire && !flush_fire) begin
      value_q[bus.cdb_tag] <= bus.cdb_value;
    end
  end
endmodule

// File: tb/tb_rob.sv
// Randomized bench for rob, checked against a queue-based program-order model.
module tb_rob;
  logic clk;
  logic rst_n;

  rob_if #(.TAG_W(5), .XLEN(32)) bus ();

  rob #(.DEPTH(32), .TAG_W(5), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failures;
  bit checksEnabled;

  // Model: in-flight tags in program order plus per-tag result storage.
  int          order[$];
  int          nextTag;
  bit          flushM;
  bit          readyM [32];
  bit          mispM  [32];
  int          rdM    [32];
  logic [31:0] valM   [32];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit isBusy(input int t);
    foreach (order[i]) if (order[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compareAll();
    int headT;
    bit eAR, eCV, byp, eSR;
    int st;
    headT = (order.size() > 0) ? order[0] : nextTag;
    st    = int'(bus.src_tag);
    eAR   = (order.size() != 32) && !flushM;
    eCV   = (order.size() > 0) && readyM[headT] && !flushM;
    byp   = bus.cdb_valid && (int'(bus.cdb_tag) == st) && isBusy(st);
    eSR   = readyM[st] || byp;
    checkOutput("alloc_ready", 32'(bus.alloc_ready), 32'(eAR));
    checkOutput("alloc_tag", 32'(bus.alloc_tag), 32'(nextTag));
    checkOutput("commit_valid", 32'(bus.commit_valid), 32'(eCV));
    checkOutput("flush", 32'(bus.flush), 32'(flushM));
    checkOutput("src_ready", 32'(bus.src_ready), 32'(eSR));
    if (eCV) begin
      checkOutput("commit_tag", 32'(bus.commit_tag), 32'(headT));
      checkOutput("commit_rd", 32'(bus.commit_rd), 32'(rdM[headT]));
      checkOutput("commit_value", bus.commit_value, valM[headT]);
    end
    if (eSR) begin
      checkOutput("src_value", bus.src_value, byp ? bus.cdb_value : valM[st]);
    end
  endtask

  task automatic modelStep();
    bit aFire, cFire, comV;
    int ct;
    if (!rst_n) begin
      order.delete();
      nextTag = 0;
      flushM  = 1'b0;
      for (int i = 0; i < 32; i++) begin
        readyM[i] = 1'b0;
        mispM[i]  = 1'b0;
      end
      return;
    end
    ct    = int'(bus.cdb_tag);
    aFire = bus.alloc_valid && (order.size() != 32) && !flushM;
    cFire = bus.cdb_valid && isBusy(ct) && !flushM;
    comV  = (order.size() > 0) && readyM[order[0]] && !flushM;
    if (comV && mispM[order[0]]) begin
      order.delete();
      nextTag = 0;
      flushM  = 1'b1;
      return;
    end
    flushM = 1'b0;
    if (comV) void'(order.pop_front());
    if (cFire) begin
      readyM[ct] = 1'b1;
      valM[ct]   = bus.cdb_value;
      mispM[ct]  = bus.cdb_mispredict;
    end
    if (aFire) begin
      readyM[nextTag] = 1'b0;
      mispM[nextTag]  = 1'b0;
      rdM[nextTag]    = int'(bus.alloc_rd);
      order.push_back(nextTag);
      nextTag = (nextTag + 1) % 32;
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic av, input logic [4:0] ard,
                               input logic cv, input logic [4:0] ctag, input logic [31:0] cval,
                               input logic cmis, input logic [4:0] stag);
    @(negedge clk);
    rst_n              = rstn;
    bus.alloc_valid    = av;
    bus.alloc_rd       = ard;
    bus.cdb_valid      = cv;
    bus.cdb_tag        = ctag;
    bus.cdb_value      = cval;
    bus.cdb_mispredict = cmis;
    bus.src_tag        = stag;
    #1;
    if (checksEnabled) compareAll();
    modelStep();
    if (!rstn) checksEnabled = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [4:0] ctag;
    int allocPct;
    tests = 0;
    failures = 0;
    checksEnabled = 1'b0;
    nextTag = 0;
    flushM = 1'b0;
    rst_n = 1'b0;
    bus.alloc_valid = 0; bus.alloc_rd = 0; bus.cdb_valid = 0; bus.cdb_tag = 0;
    bus.cdb_value = 0; bus.cdb_mispredict = 0; bus.src_tag = 0;

    // Reset, first allocation, then out-of-order results retiring in order.
    doReset();
    idle(1);
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 2, 32'h22, 0, 2);
    applyStimulus(1, 0, 0, 1, 0, 32'h00, 0, 0);
    idle(3);
    applyStimulus(1, 0, 0, 1, 1, 32'h11, 0, 1);
    idle(3);

    // Fill to full, retire the head while dispatch keeps pushing, wrap the tag.
    doReset();
    for (int i = 0; i < 32; i++) applyStimulus(1, 1, 5'(i), 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 7, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 7, 1, 0, 32'hA0, 0, 0);
    applyStimulus(1, 1, 8, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 9, 0, 0, 0, 0, 0);

    // Operand bypass from the CDB, then the same value from the entry.
    applyStimulus(1, 0, 0, 1, 4, 32'hDEAD, 0, 4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4);

    // Mispredict at the head squashes the younger entries.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 5'(i + 10), 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 32'h40, 1, 0);
    applyStimulus(1, 1, 2, 1, 1, 32'h41, 0, 1);
    for (int i = 2; i < 6; i++) applyStimulus(1, 0, 0, 1, 5'(i), 32'h50 + i, 0, 5'(i));
    idle(2);

    // A CDB write to an idle tag leaves it not ready once allocated.
    doReset();
    applyStimulus(1, 0, 0, 1, 9, 32'h99, 0, 9);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 5'(i), 0, 0, 0, 0, 9);
    idle(1);

    // Random traffic with occasional mid-stream resets.
    for (int c = 0; c < 4000; c++) begin
      allocPct = ((c / 500) % 2 == 1) ? 85 : 45;
      if (order.size() > 0 && $urandom_range(3) != 0)
        ctag = 5'(order[$urandom_range(order.size() - 1)]);
      else
        ctag = 5'($urandom_range(31));
      applyStimulus(($urandom_range(399) != 0),
                    ($urandom_range(99) < allocPct),
                    5'($urandom_range(31)),
                    ($urandom_range(2) != 0),
                    ctag,
                    $urandom,
                    ($urandom_range(99) < 3),
                    ($urandom_range(1) == 1) ? ctag : 5'($urandom_range(31)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
